// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial program loader; assembles MSB-first bytes and writes
//               16 words into program memory. Optional trailing checksum when
//               PROG_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req,
  input  logic       ser_strobe,
  input  logic       ser_bit,
  input  logic [3:0] pc_in,
  output logic [3:0] mem_address,
  output logic [3:0] mem_opcode,
  output logic [3:0] mem_immediate,
  output logic       mem_write,
  output logic       busy,
  output logic       done,
  output logic       chk_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd3;
`endif
  localparam logic [3:0] C_LAST_WORD = 4'd15;
  localparam logic [2:0] C_LAST_BIT  = 3'd7;

  logic [2:0] r_state;
  logic [3:0] r_word;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic       r_load_req_d;

  logic       w_busy;
  logic       w_start;
  logic [7:0] w_shift_in;

  assign w_busy     = (r_state == ST_SHIFT) || (r_state == ST_WRITE)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (r_state == ST_CHECK)
`endif
                      ;
  // A new load is accepted only from an idle or finished loader.
  assign w_start    = load_req && !r_load_req_d &&
                      ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_shift_in = {r_shift[6:0], ser_bit};

  assign busy          = w_busy;
  assign done          = (r_state == ST_DONE);
  assign mem_write     = (r_state == ST_WRITE);
  assign mem_address   = w_busy ? r_word : pc_in;
  assign mem_immediate = r_shift[7:4];
  assign mem_opcode    = r_shift[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_word       <= 4'd0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_load_req_d <= 1'b0;
    end else begin
      r_load_req_d <= load_req;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state <= ST_SHIFT;
            r_word  <= 4'd0;
            r_bit   <= 3'd0;
          end
        end
        ST_SHIFT: begin
          if (ser_strobe) begin
            r_shift <= w_shift_in;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == C_LAST_BIT) begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (r_word == C_LAST_WORD) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state <= ST_CHECK;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_word  <= r_word + 4'd1;
            r_state <= ST_SHIFT;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (ser_strobe) begin
            r_shift <= w_shift_in;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == C_LAST_BIT) begin
              r_state <= ST_DONE;
            end
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_chk_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= 8'd0;
      r_chk_err <= 1'b0;
    end else if (w_start) begin
      r_sum     <= 8'd0;
      r_chk_err <= 1'b0;
    end else if (r_state == ST_WRITE) begin
      r_sum <= r_sum + r_shift;
    end else if ((r_state == ST_CHECK) && ser_strobe && (r_bit == C_LAST_BIT)) begin
      r_chk_err <= (w_shift_in != r_sum);
    end
  end

  assign chk_err = r_chk_err;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomized self-checking bench for prog_loader against a
//               byte-list reference model of the expected memory writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       load_req;
  logic       ser_strobe;
  logic       ser_bit;
  logic [3:0] pc_in;
  logic [3:0] mem_address;
  logic [3:0] mem_opcode;
  logic [3:0] mem_immediate;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic       chk_err;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] load_bytes [16];
  logic [7:0] cks;
  logic [3:0] wq_addr [$];
  logic [7:0] wq_data [$];

  prog_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_req      (load_req),
    .ser_strobe    (ser_strobe),
    .ser_bit       (ser_bit),
    .pc_in         (pc_in),
    .mem_address   (mem_address),
    .mem_opcode    (mem_opcode),
    .mem_immediate (mem_immediate),
    .mem_write     (mem_write),
    .busy          (busy),
    .done          (done),
    .chk_err       (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side observer: every cycle with mem_write high is one write.
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      wq_addr.push_back(mem_address);
      wq_data.push_back({mem_immediate, mem_opcode});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      ser_bit    = b[i];
      ser_strobe = 1'b1;
      step();
      ser_strobe = 1'b0;
      if (i != 8 - n) repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // After the final bit the next cycle is the WRITE cycle; optionally fire a
  // stray strobe into it, which the loader must drop.
  task automatic send_byte(input logic [7:0] b, input bit inject);
    send_bits(b, 8);
    if (inject) begin
      ser_bit    = $urandom_range(0, 1);
      ser_strobe = 1'b1;
      step();
      ser_strobe = 1'b0;
    end else begin
      step();
    end
    repeat ($urandom_range(0, 1)) step();
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_wcount"}, wq_addr.size(), 16);
    n = (wq_addr.size() < 16) ? wq_addr.size() : 16;
    for (int k = 0; k < n; k++) begin
      check({tag, "_waddr"}, {28'd0, wq_addr[k]}, k);
      check({tag, "_wdata"}, {24'd0, wq_data[k]}, {24'd0, load_bytes[k]});
    end
  endtask

  task automatic run_load(input string tag, input bit inject, input bit repulse, input bit hold);
    logic [7:0] sum;
    logic       exp_chk;
    wq_addr.delete();
    wq_data.delete();
    load_req = 1'b1;
    step();
    if (!hold) load_req = 1'b0;
    check({tag, "_start_busy"}, {31'd0, busy}, 1);
    check({tag, "_start_done"}, {31'd0, done}, 0);
    for (int k = 0; k < 16; k++) begin
      pc_in = $urandom_range(0, 15);
      if (repulse && !hold && k == 6) load_req = 1'b1;
      if (repulse && !hold && k == 9) load_req = 1'b0;
      send_byte(load_bytes[k], inject && ($urandom_range(0, 1) == 1));
      if (k < 15) begin
        check({tag, "_addr_mid"}, {28'd0, mem_address}, k + 1);
        check({tag, "_busy_mid"}, {31'd0, busy}, 1);
      end
    end
    sum = 8'd0;
    for (int k = 0; k < 16; k++) sum = sum + load_bytes[k];
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(cks, 1'b0);
    exp_chk = (sum != cks);
`else
    exp_chk = 1'b0;
`endif
    step();
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    check({tag, "_chk_err"}, {31'd0, chk_err}, {31'd0, exp_chk});
    check({tag, "_addr_pc"}, {28'd0, mem_address}, {28'd0, pc_in});
    check_writes(tag);
  endtask

  task automatic rand_bytes(input bit good_cks);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 16; k++) begin
      load_bytes[k] = $urandom_range(0, 255);
      s = s + load_bytes[k];
    end
    cks = good_cks ? s : s + 8'd1;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_req   = 1'b0;
    ser_strobe = 1'b0;
    ser_bit    = 1'b0;
    pc_in      = 4'hA;
    #12;
    check("rst_addr", {28'd0, mem_address}, 32'hA);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_mem_write", {31'd0, mem_write}, 0);
    check("rst_chk_err", {31'd0, chk_err}, 0);
    check("rst_data", {24'd0, mem_immediate, mem_opcode}, 0);
    pc_in = 4'h5;
    #1;
    check("rst_addr_pass", {28'd0, mem_address}, 32'h5);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_busy", {31'd0, busy}, 0);

    // Ascending bytes 0x00..0x0F
    for (int k = 0; k < 16; k++) load_bytes[k] = k[7:0];
    cks = 8'h78;
    run_load("seq", 1'b0, 1'b0, 1'b0);

    // 0xB3 at word 0, restart from DONE
    rand_bytes(1'b1);
    load_bytes[0] = 8'hB3;
    cks = 8'd0;
    for (int k = 0; k < 16; k++) cks = cks + load_bytes[k];
    run_load("b3", 1'b0, 1'b0, 1'b0);
    check("b3_imm", {28'd0, wq_data.size() > 0 ? wq_data[0][7:4] : 4'h0}, 32'hB);
    check("b3_op", {28'd0, wq_data.size() > 0 ? wq_data[0][3:0] : 4'h0}, 32'h3);

    // Randomized loads with stray strobes and load_req re-pulses
    for (int r = 0; r < 3; r++) begin
      rand_bytes($urandom_range(0, 1) == 1);
      run_load("rnd", 1'b1, r != 0, 1'b0);
    end

    // Strobes while DONE are ignored
    wq_addr.delete();
    wq_data.delete();
    repeat (10) begin
      ser_bit    = $urandom_range(0, 1);
      ser_strobe = $urandom_range(0, 1);
      step();
    end
    ser_strobe = 1'b0;
    check("done_idle_strobe", {31'd0, done}, 1);
    check("done_no_write", wq_addr.size(), 0);

    // Held-high load_req starts once and does not retrigger
    rand_bytes(1'b1);
    run_load("hold", 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    check("hold_no_retrig_done", {31'd0, done}, 1);
    check("hold_no_retrig_busy", {31'd0, busy}, 0);
    load_req = 1'b0;
    step();

    // Reset after 5 words + 3 bits, then a fresh load
    rand_bytes(1'b1);
    wq_addr.delete();
    wq_data.delete();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(load_bytes[k], 1'b0);
    send_bits(8'hFF, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_addr", {28'd0, mem_address}, {28'd0, pc_in});
    check("midrst_wcount", wq_addr.size(), 5);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("midrst_no_write5", wq_addr.size(), 5);
    check("midrst_idle", {31'd0, done}, 0);
    rand_bytes(1'b1);
    run_load("after_rst", 1'b0, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    for (int k = 0; k < 16; k++) load_bytes[k] = 8'h01;
    cks = 8'h10;
    run_load("cks_good", 1'b0, 1'b0, 1'b0);
    cks = 8'h11;
    run_load("cks_bad", 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
